iter_multiplier: RTL and testbench

Iterative 32x32 shift-add multiplier sitting between register-file read and write-back. It takes the two read-port values, captured as the operands, and computes a 64-bit product over multiple cycles. It then presents the low word with a one-cycle write-enable pulse and destination index, which drive the register file's `we3`/`ra3`/`wd3`. It stalls the pipeline through `busy`.

---
 rtl/iter_mul_pkg.sv | 17 +
 rtl/mul_negate.sv | 17 +
 rtl/iter_multiplier.sv | 141 ++++++++++++++
 tb/tb_iter_multiplier.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/iter_mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
//   mul_state_t : FSM state encoding (IDLE, CALC, FIX, DONE)
//   MUL_ITERS   : number of shift-add iterations (one per operand bit)
//   MUL_CNT_W   : width of the iteration counter
package iter_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

    localparam int MUL_ITERS = 32;
    localparam int MUL_CNT_W = 5;

endpackage

// File: rtl/mul_negate.sv
// Combinational conditional two's complement.
//   value  : input operand
//   neg    : 1 = return -value, 0 = return value unchanged
//   result : conditionally negated value
module mul_negate #(
    parameter int W = 64
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    always_comb begin
        result = neg ? (~value + W'(1)) : value;
    end

endmodule

// File: rtl/iter_multiplier.sv
// Iterative 32x32 shift-add multiplier between register read and write-back.
// Optional feature macro: ITER_MUL_ACC_EN (multiply-accumulate in FIX).
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   start, op_signed     : request and signedness, sampled with a/b/rd_in
//   a, b                 : operands from the register-file read ports
//   rd_in                : destination register index
//   busy                 : unit occupied (CALC/FIX), upstream holds instruction
//   done, wb_we          : one-cycle completion / write-back enable pulse
//   wb_addr              : captured destination index
//   result_hi, result_lo : 64-bit product, held until the next FIX
//   acc_en, acc_hi/lo    : (ITER_MUL_ACC_EN only) addend sampled with start
module iter_multiplier
    import iter_mul_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op_signed,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [REG_AW-1:0] rd_in,
`ifdef ITER_MUL_ACC_EN
    input  logic              acc_en,
    input  logic [WIDTH-1:0]  acc_hi,
    input  logic [WIDTH-1:0]  acc_lo,
`endif
    output logic              busy,
    output logic              done,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_addr,
    output logic [WIDTH-1:0]  result_lo,
    output logic [WIDTH-1:0]  result_hi
);

    mul_state_t state, state_nxt;

    logic [WIDTH-1:0]     mcand;    // |a|
    logic [2*WIDTH-1:0]   prod;     // {accumulator, remaining multiplier bits}
    logic [MUL_CNT_W-1:0] cnt;
    logic                 neg;
    logic [REG_AW-1:0]    rd_q;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod_shift, prod_fix, prod_final;
    logic                 take;
    logic                 last_iter;

    // A new request is accepted only when the unit is free or just finishing.
    assign take      = start && (state == IDLE || state == DONE);
    assign last_iter = (cnt == MUL_CNT_W'(MUL_ITERS - 1));

    // Magnitudes; -0x80000000 wraps back to 0x80000000, which is the correct
    // unsigned magnitude, so no extra bit is needed.
    assign a_mag = (op_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign b_mag = (op_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    // Add into the upper half with one carry bit, then shift the whole
    // {carry, acc, multiplier} right by one; the consumed multiplier LSB drops.
    assign sum        = {1'b0, prod[2*WIDTH-1:WIDTH]}
                      + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign prod_shift = {sum, prod[WIDTH-1:1]};

    mul_negate #(.W(2*WIDTH)) u_negate (
        .value  (prod),
        .neg    (neg),
        .result (prod_fix)
    );

`ifdef ITER_MUL_ACC_EN
    logic [2*WIDTH-1:0] acc_q;
    assign prod_final = prod_fix + acc_q;
`else
    assign prod_final = prod_fix;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy  = (state == CALC) || (state == FIX);
        done  = (state == DONE);
        wb_we = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand     <= '0;
            prod      <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            rd_q      <= '0;
            wb_addr   <= '0;
            result_lo <= '0;
            result_hi <= '0;
`ifdef ITER_MUL_ACC_EN
            acc_q     <= '0;
`endif
        end else begin
            if (take) begin
                mcand <= a_mag;
                prod  <= {{WIDTH{1'b0}}, b_mag};
                cnt   <= '0;
                neg   <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                rd_q  <= rd_in;
`ifdef ITER_MUL_ACC_EN
                acc_q <= acc_en ? {acc_hi, acc_lo} : '0;
`endif
            end else if (state == CALC) begin
                prod <= prod_shift;
                cnt  <= cnt + MUL_CNT_W'(1);
            end
            if (state == FIX) begin
                result_hi <= prod_final[2*WIDTH-1:WIDTH];
                result_lo <= prod_final[WIDTH-1:0];
                wb_addr   <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_iter_multiplier.sv
// Directed self-checking bench for iter_multiplier.
module tb_iter_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op_signed;
    logic [31:0] a, b;
    logic [3:0]  rd_in;
    logic        busy, done, wb_we;
    logic [3:0]  wb_addr;
    logic [31:0] result_lo, result_hi;
`ifdef ITER_MUL_ACC_EN
    logic        acc_en;
    logic [31:0] acc_hi, acc_lo;
`endif

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    iter_multiplier #(.WIDTH(32), .REG_AW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_signed (op_signed),
        .a         (a),
        .b         (b),
        .rd_in     (rd_in),
`ifdef ITER_MUL_ACC_EN
        .acc_en    (acc_en),
        .acc_hi    (acc_hi),
        .acc_lo    (acc_lo),
`endif
        .busy      (busy),
        .done      (done),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .result_lo (result_lo),
        .result_hi (result_hi)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request now (caller is #1 after a rising edge), hold it over one edge.
    task automatic launch(input logic [31:0] av, input logic [31:0] bv,
                          input logic sg, input logic [3:0] rd);
        a = av; b = bv; op_signed = sg; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen, bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!done && cycles < 60);
    endtask

    task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic sg, input logic [63:0] exp);
        int c;
        launch(av, bv, sg, 4'd7);
        wait_done(c);
        chk({tag, "_lat"}, 64'(c), 64'd33);
        chk({tag, "_prod"}, {result_hi, result_lo}, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        reset = 1'b1; start = 1'b0; op_signed = 1'b0;
        a = '0; b = '0; rd_in = '0;
`ifdef ITER_MUL_ACC_EN
        acc_en = 1'b0; acc_hi = '0; acc_lo = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  64'(busy),    64'd0);
        chk("rst_done",  64'(done),    64'd0);
        chk("rst_we",    64'(wb_we),   64'd0);
        chk("rst_addr",  64'(wb_addr), 64'd0);
        chk("rst_lo",    64'(result_lo), 64'd0);
        chk("rst_hi",    64'(result_hi), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 7 * 6, full protocol check
        launch(32'd7, 32'd6, 1'b0, 4'd3);
        chk("u76_busy", 64'(busy), 64'd1);
        wait_done(n);
        chk("u76_lat",  64'(n), 64'd33);
        chk("u76_prod", {result_hi, result_lo}, 64'h0000_0000_0000_002A);
        chk("u76_addr", 64'(wb_addr), 64'd3);
        chk("u76_we",   64'(wb_we), 64'd1);
        chk("u76_busy_done", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("u76_done_1cyc", 64'(done), 64'd0);
        chk("u76_we_1cyc",   64'(wb_we), 64'd0);
        chk("u76_hold",      {result_hi, result_lo}, 64'h0000_0000_0000_002A);

        run("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        run("u_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1);
        run("s_min2", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        run("u_max2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run("s_m1x7", 32'hFFFF_FFFF, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9);

        // start during CALC is ignored
        launch(32'd2, 32'd3, 1'b0, 4'd1);
        repeat (5) @(posedge clk);
        #1;
        launch(32'd9, 32'd9, 1'b0, 4'd2);
        wait_done(n);
        chk("ign_lat",  64'(n), 64'd27);
        chk("ign_prod", {result_hi, result_lo}, 64'd6);
        chk("ign_addr", 64'(wb_addr), 64'd1);

        // back-to-back: start while in DONE
        launch(32'd4, 32'd5, 1'b0, 4'd5);
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_keep", {result_hi, result_lo}, 64'd6);
        wait_done(n);
        chk("b2b_lat",  64'(n), 64'd33);
        chk("b2b_prod", {result_hi, result_lo}, 64'd20);
        chk("b2b_addr", 64'(wb_addr), 64'd5);
        @(posedge clk); #1;

        // reset at iteration 10 discards the operation
        launch(32'd100, 32'd100, 1'b0, 4'd9);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_addr", 64'(wb_addr), 64'd0);
        chk("mrst_res",  {result_hi, result_lo}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("mrst_quiet", 64'(seen), 64'd0);
        launch(32'd7, 32'd6, 1'b0, 4'd3);
        wait_done(n);
        chk("mrst_lat",  64'(n), 64'd33);
        chk("mrst_prod", {result_hi, result_lo}, 64'd42);
        @(posedge clk); #1;

        // reset and start on the same edge: reset wins
        reset = 1'b1;
        launch(32'd3, 32'd3, 1'b0, 4'd4);
        reset = 1'b0;
        chk("rs_busy", 64'(busy), 64'd0);

`ifdef ITER_MUL_ACC_EN
        acc_en = 1'b1; acc_hi = 32'd0; acc_lo = 32'd10;
        run("acc", 32'd2, 32'd3, 1'b0, 64'd16);
        acc_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
